// File: rtl/link_pair_power_sequencer.sv
// Per-pair power sequencer for pairs 1236/5478: qualify, soft-start, supervise, fault.
// Optional macro LINK_POWER_AUTO_RETRY_EN adds a backoff timer that leaves FAULT on its own.
module link_pair_power_sequencer #(
    parameter int DETECT_CYCLES  = 16,
    parameter int RAMP_CYCLES    = 64,
    parameter int MPS_TIMEOUT    = 256,
    parameter int BACKOFF_CYCLES = 1024
) (
    input  logic       Clock100MhzP,
    input  logic       ResetN,
    input  logic       Sense1236,
    input  logic       Sense5478,
    input  logic       OverCurrent,
    input  logic       ReArm,
    output logic       Enable1236,
    output logic       Enable5478,
    output logic       PowerGood,
    output logic       FaultLatched,
    output logic [2:0] State
);

    // state   | meaning
    // IDLE    | no pair powered, waiting for any signature
    // DETECT  | counting consecutive valid signature samples per pair
    // RAMP    | soft-start on masked pairs, over-current blanked for first half
    // POWERED | supervising over-current and MPS
    // FAULT   | power removed until ReArm (or backoff expiry)
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DETECT  = 3'd1;
    localparam logic [2:0] S_RAMP    = 3'd2;
    localparam logic [2:0] S_POWERED = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    localparam int DW = $clog2(DETECT_CYCLES + 1);
    localparam int RW = $clog2(RAMP_CYCLES + 1);
    localparam int MW = $clog2(MPS_TIMEOUT + 1);

    localparam logic [DW-1:0] DET_MAX   = DW'(DETECT_CYCLES);
    localparam logic [RW-1:0] RAMP_MAX  = RW'(RAMP_CYCLES);
    localparam logic [RW-1:0] RAMP_HALF = RW'(RAMP_CYCLES / 2);
    localparam logic [MW-1:0] MPS_MAX   = MW'(MPS_TIMEOUT);

    if (DETECT_CYCLES < 2 || RAMP_CYCLES < 2 || MPS_TIMEOUT < 2 || BACKOFF_CYCLES < 1) begin : g_bad_param
        $error("link_pair_power_sequencer: parameter out of range");
    end

    logic [1:0]    sense;
    logic [2:0]    state_nxt;
    logic [DW-1:0] det_a, det_b, det_a_nxt, det_b_nxt;
    logic [RW-1:0] ramp_cnt, ramp_cnt_nxt;
    logic [MW-1:0] mps_cnt, mps_cnt_nxt;
    logic [1:0]    mask, mask_nxt;
    logic [1:0]    en_nxt;
    logic          mps_lost;

`ifdef LINK_POWER_AUTO_RETRY_EN
    localparam int BW = $clog2(BACKOFF_CYCLES + 1);
    localparam logic [BW-1:0] BO_MAX = BW'(BACKOFF_CYCLES);
    logic [BW-1:0] bo_cnt, bo_cnt_nxt;
`endif

    assign sense    = {Sense5478, Sense1236};
    assign mps_lost = ((mask & sense) == 2'b00);

    always_comb begin
        state_nxt    = State;
        det_a_nxt    = det_a;
        det_b_nxt    = det_b;
        ramp_cnt_nxt = ramp_cnt;
        mps_cnt_nxt  = mps_cnt;
        mask_nxt     = mask;
`ifdef LINK_POWER_AUTO_RETRY_EN
        bo_cnt_nxt   = '0;
`endif
        case (State)
            S_IDLE: begin
                mask_nxt = 2'b00;
                if (sense != 2'b00) begin
                    state_nxt = S_DETECT;
                    det_a_nxt = '0;
                    det_b_nxt = '0;
                end
            end
            S_DETECT: begin
                det_a_nxt = !Sense1236 ? '0 : (det_a == DET_MAX) ? det_a : det_a + 1'b1;
                det_b_nxt = !Sense5478 ? '0 : (det_b == DET_MAX) ? det_b : det_b + 1'b1;
                if (sense == 2'b00) begin
                    state_nxt = S_IDLE;
                end else if (det_a_nxt == DET_MAX || det_b_nxt == DET_MAX) begin
                    mask_nxt     = {det_b_nxt == DET_MAX, det_a_nxt == DET_MAX};
                    state_nxt    = S_RAMP;
                    ramp_cnt_nxt = '0;
                end
            end
            S_RAMP: begin
                if (OverCurrent && ramp_cnt >= RAMP_HALF) begin
                    state_nxt = S_FAULT;
                end else begin
                    ramp_cnt_nxt = (ramp_cnt == RAMP_MAX) ? ramp_cnt : ramp_cnt + 1'b1;
                    if (ramp_cnt_nxt == RAMP_MAX) begin
                        state_nxt   = S_POWERED;
                        mps_cnt_nxt = '0;
                    end
                end
            end
            S_POWERED: begin
                // Over-current beats a coincident MPS timeout.
                if (OverCurrent) begin
                    state_nxt = S_FAULT;
                end else begin
                    mps_cnt_nxt = !mps_lost ? '0 : (mps_cnt == MPS_MAX) ? mps_cnt : mps_cnt + 1'b1;
                    if (mps_cnt_nxt == MPS_MAX) begin
                        state_nxt = S_IDLE;
                        mask_nxt  = 2'b00;
                    end
                end
            end
            S_FAULT: begin
                if (ReArm) begin
                    state_nxt = S_IDLE;
                    mask_nxt  = 2'b00;
                end
`ifdef LINK_POWER_AUTO_RETRY_EN
                else begin
                    bo_cnt_nxt = (bo_cnt == BO_MAX) ? bo_cnt : bo_cnt + 1'b1;
                    if (bo_cnt_nxt == BO_MAX) begin
                        state_nxt = S_IDLE;
                        mask_nxt  = 2'b00;
                    end
                end
`endif
            end
            default: begin
                state_nxt = S_IDLE;
                mask_nxt  = 2'b00;
            end
        endcase
    end

    assign en_nxt = (state_nxt == S_RAMP || state_nxt == S_POWERED) ? mask_nxt : 2'b00;

    always_ff @(posedge Clock100MhzP) begin
        if (!ResetN) begin
            State        <= S_IDLE;
            det_a        <= '0;
            det_b        <= '0;
            ramp_cnt     <= '0;
            mps_cnt      <= '0;
            mask         <= 2'b00;
            Enable1236   <= 1'b0;
            Enable5478   <= 1'b0;
            PowerGood    <= 1'b0;
            FaultLatched <= 1'b0;
        end else begin
            State        <= state_nxt;
            det_a        <= det_a_nxt;
            det_b        <= det_b_nxt;
            ramp_cnt     <= ramp_cnt_nxt;
            mps_cnt      <= mps_cnt_nxt;
            mask         <= mask_nxt;
            Enable1236   <= en_nxt[0];
            Enable5478   <= en_nxt[1];
            PowerGood    <= (state_nxt == S_POWERED);
            FaultLatched <= (state_nxt == S_FAULT);
        end
    end

`ifdef LINK_POWER_AUTO_RETRY_EN
    always_ff @(posedge Clock100MhzP) begin
        if (!ResetN) begin
            bo_cnt <= '0;
        end else begin
            bo_cnt <= bo_cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_link_pair_power_sequencer.sv
// Bench for link_pair_power_sequencer (default build): directed vector table plus
// randomized stimulus against a cycle-level reference model.
module tb_link_pair_power_sequencer;

    localparam int DET  = 16;
    localparam int RAMP = 64;
    localparam int MPS  = 256;
    localparam int BO   = 1024;

    logic       clk = 1'b0;
    logic       rst_n, s1, s2, oc, rearm;
    logic       en1236, en5478, pg, fl;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    link_pair_power_sequencer #(
        .DETECT_CYCLES (DET),
        .RAMP_CYCLES   (RAMP),
        .MPS_TIMEOUT   (MPS),
        .BACKOFF_CYCLES(BO)
    ) dut (
        .Clock100MhzP(clk),
        .ResetN      (rst_n),
        .Sense1236   (s1),
        .Sense5478   (s2),
        .OverCurrent (oc),
        .ReArm       (rearm),
        .Enable1236  (en1236),
        .Enable5478  (en5478),
        .PowerGood   (pg),
        .FaultLatched(fl),
        .State       (state)
    );

    always #5 clk = ~clk;

    // Reference model: phase number plus plain integer run lengths.
    int m_phase = 0;
    int m_run_a = 0, m_run_b = 0, m_ramp = 0, m_low = 0;
    bit m_mask_a = 0, m_mask_b = 0;

    task automatic model_step(input logic r, input logic a, input logic b,
                              input logic o, input logic ra);
        bit held;
        if (!r) begin
            m_phase = 0; m_run_a = 0; m_run_b = 0; m_ramp = 0; m_low = 0;
            m_mask_a = 0; m_mask_b = 0;
        end else begin
            case (m_phase)
                0: if (a || b) begin m_phase = 1; m_run_a = 0; m_run_b = 0; end
                1: begin
                    m_run_a = a ? m_run_a + 1 : 0;
                    m_run_b = b ? m_run_b + 1 : 0;
                    if (!a && !b) m_phase = 0;
                    else if (m_run_a >= DET || m_run_b >= DET) begin
                        m_mask_a = (m_run_a >= DET);
                        m_mask_b = (m_run_b >= DET);
                        m_phase = 2; m_ramp = 0;
                    end
                end
                2: begin
                    if (o && m_ramp >= RAMP / 2) m_phase = 4;
                    else begin
                        m_ramp++;
                        if (m_ramp == RAMP) begin m_phase = 3; m_low = 0; end
                    end
                end
                3: begin
                    if (o) m_phase = 4;
                    else begin
                        held = (m_mask_a && a) || (m_mask_b && b);
                        m_low = held ? 0 : m_low + 1;
                        if (m_low == MPS) begin m_phase = 0; m_mask_a = 0; m_mask_b = 0; end
                    end
                end
                default: if (ra) begin m_phase = 0; m_mask_a = 0; m_mask_b = 0; end
            endcase
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit powered;
        powered = (m_phase == 2 || m_phase == 3);
        check("model.state", int'(state), m_phase);
        check("model.en1236", int'(en1236), int'(powered && m_mask_a));
        check("model.en5478", int'(en5478), int'(powered && m_mask_b));
        check("model.pg", int'(pg), int'(m_phase == 3));
        check("model.fl", int'(fl), int'(m_phase == 4));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rst_n, s1, s2, oc, rearm);
        #1;
        check_model();
    endtask

    typedef struct {
        logic       r, a, b, o, ra;
        int         cycles;
        logic [2:0] st;
        logic [1:0] en;
        logic       pg, fl;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, a, b, o, ra, input int n,
                                input logic [2:0] st, input logic [1:0] en,
                                input logic p, input logic f);
        vec_t v;
        v.r = r; v.a = a; v.b = b; v.o = o; v.ra = ra; v.cycles = n;
        v.st = st; v.en = en; v.pg = p; v.fl = f;
        vecs.push_back(v);
    endfunction

    initial begin
        rst_n = 1'b0; s1 = 1'b0; s2 = 1'b0; oc = 1'b0; rearm = 1'b0;

        //  r  a  b  o  ra  n     st  en    pg fl     en = {5478,1236}
        add(0, 0, 0, 0, 0,  2,    0, 2'b00, 0, 0);
        add(1, 1, 0, 0, 0,  1,    1, 2'b00, 0, 0);
        add(1, 1, 0, 0, 0,  15,   1, 2'b00, 0, 0);
        add(1, 1, 0, 0, 0,  1,    2, 2'b01, 0, 0);   // RAMP at edge 17
        add(1, 1, 0, 0, 0,  63,   2, 2'b01, 0, 0);
        add(1, 1, 0, 0, 0,  1,    3, 2'b01, 1, 0);   // POWERED at edge 81
        add(1, 0, 0, 0, 0,  255,  3, 2'b01, 1, 0);
        add(1, 1, 0, 0, 0,  1,    3, 2'b01, 1, 0);
        add(1, 0, 0, 0, 0,  255,  3, 2'b01, 1, 0);
        add(1, 0, 0, 0, 0,  1,    0, 2'b00, 0, 0);   // 256th low sample
        add(1, 1, 0, 0, 0,  1,    1, 2'b00, 0, 0);
        add(1, 1, 0, 0, 0,  15,   1, 2'b00, 0, 0);
        add(1, 0, 0, 0, 0,  1,    0, 2'b00, 0, 0);   // drop at count 15
        add(1, 1, 0, 0, 0,  1,    1, 2'b00, 0, 0);
        add(1, 1, 0, 0, 0,  15,   1, 2'b00, 0, 0);
        add(1, 0, 1, 0, 0,  1,    1, 2'b00, 0, 0);
        add(1, 1, 1, 0, 0,  14,   1, 2'b00, 0, 0);
        add(1, 1, 1, 0, 0,  1,    2, 2'b10, 0, 0);   // only 5478 reached 16
        add(1, 1, 1, 0, 0,  10,   2, 2'b10, 0, 0);
        add(1, 1, 1, 1, 0,  1,    2, 2'b10, 0, 0);   // OC at ramp 10 blanked
        add(1, 1, 1, 0, 0,  29,   2, 2'b10, 0, 0);
        add(1, 1, 1, 1, 0,  1,    4, 2'b00, 0, 1);   // OC at ramp 40
        add(1, 1, 1, 0, 0,  1023, 4, 2'b00, 0, 1);
        add(1, 1, 1, 0, 0,  1,    4, 2'b00, 0, 1);
        add(1, 1, 1, 0, 0,  976,  4, 2'b00, 0, 1);
        add(1, 1, 1, 0, 1,  1,    0, 2'b00, 0, 0);
        add(1, 1, 1, 0, 0,  1,    1, 2'b00, 0, 0);
        add(1, 1, 1, 0, 0,  15,   1, 2'b00, 0, 0);
        add(1, 1, 1, 0, 0,  1,    2, 2'b11, 0, 0);
        add(1, 1, 1, 0, 0,  63,   2, 2'b11, 0, 0);
        add(1, 1, 1, 0, 0,  1,    3, 2'b11, 1, 0);
        add(1, 0, 1, 0, 0,  300,  3, 2'b11, 1, 0);   // 5478 holds MPS
        add(1, 1, 0, 0, 0,  300,  3, 2'b11, 1, 0);
        add(1, 0, 0, 0, 0,  255,  3, 2'b11, 1, 0);
        add(1, 0, 0, 1, 0,  1,    4, 2'b00, 0, 1);   // OC with MPS timeout
        add(1, 0, 0, 0, 1,  1,    0, 2'b00, 0, 0);
        add(1, 1, 0, 0, 0,  1,    1, 2'b00, 0, 0);
        add(1, 1, 0, 0, 0,  16,   2, 2'b01, 0, 0);
        add(1, 1, 0, 0, 0,  64,   3, 2'b01, 1, 0);
        add(0, 1, 0, 0, 0,  1,    0, 2'b00, 0, 0);   // reset mid-POWERED
        add(1, 1, 0, 0, 0,  1,    1, 2'b00, 0, 0);
        add(1, 1, 0, 0, 0,  15,   1, 2'b00, 0, 0);
        add(1, 1, 0, 0, 0,  1,    2, 2'b01, 0, 0);
        add(1, 1, 0, 0, 0,  31,   2, 2'b01, 0, 0);
        add(1, 1, 0, 1, 0,  1,    2, 2'b01, 0, 0);   // OC at ramp 31 blanked
        add(1, 1, 0, 1, 0,  1,    4, 2'b00, 0, 1);   // OC at ramp 32
        add(0, 1, 1, 1, 1,  1,    0, 2'b00, 0, 0);   // reset wins

        foreach (vecs[i]) begin
            rst_n = vecs[i].r; s1 = vecs[i].a; s2 = vecs[i].b;
            oc = vecs[i].o; rearm = vecs[i].ra;
            repeat (vecs[i].cycles) tick();
            check($sformatf("vec%0d.state", i), int'(state), int'(vecs[i].st));
            check($sformatf("vec%0d.en", i), int'({en5478, en1236}), int'(vecs[i].en));
            check($sformatf("vec%0d.pg", i), int'(pg), int'(vecs[i].pg));
            check($sformatf("vec%0d.fl", i), int'(fl), int'(vecs[i].fl));
        end

        rst_n = 1'b1; s1 = 1'b0; s2 = 1'b0; oc = 1'b0; rearm = 1'b0;
        for (int seg = 0; seg < 40; seg++) begin
            int rate, oc_rate;
            case ($urandom_range(0, 2))
                0:       rate = 8;
                1:       rate = 60;
                default: rate = 400;
            endcase
            oc_rate = ($urandom_range(0, 1) == 0) ? 150 : 0;
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(1, rate) == 1) s1 = !s1;
                if ($urandom_range(1, rate) == 1) s2 = !s2;
                oc    = (oc_rate != 0) && ($urandom_range(1, oc_rate) == 1);
                rearm = ($urandom_range(0, 49) == 0);
                rst_n = ($urandom_range(0, 2999) != 0);
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
